// File: rtl/exmem_skid_stage.sv
// -----------------------------------------------------------------------------
// exmem_skid_stage
//   EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. It holds the control bundle, PC, ALU result, store data, zero flag
//   and destination register of each instruction as it passes from EX to MEM.
//   A MEM-side stall never drops or duplicates an instruction, and a flush
//   empties the stage. When out_valid is low, out_ctrl is forced to zero, so a
//   bubble can never write the register file or memory.
//
// Optional feature (macro EXMEM_PERF_EN):
//   Adds the stall_cnt output. It counts cycles with out_valid & ~out_ready,
//   saturates at all-ones and is cleared only by Rst.
//
// Ports:
//   Clk, Rst          rising-edge clock, synchronous active-high reset
//   flush             kills every held entry; a same-cycle accept is dropped
//   in_valid/in_ready EX-side handshake
//   in_*              EX-stage fields (ctrl, pc, alu, store, zero, dst)
//   out_valid/out_ready MEM-side handshake
//   out_*             registered fields; out_ctrl is gated by out_valid
//   stall_cnt         stall-cycle counter (EXMEM_PERF_EN only)
// -----------------------------------------------------------------------------
module exmem_skid_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5,
   parameter int REG_W  = 5
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_store,
   input  logic              in_zero,
   input  logic [REG_W-1:0]  in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_store,
   output logic              out_zero,
   output logic [REG_W-1:0]  out_dst
`ifdef EXMEM_PERF_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] store;
      logic              zero;
      logic [REG_W-1:0]  dst;
   } entry_t;

   state_t state;
   entry_t in_e;
   entry_t main_q;   // drives the outputs
   entry_t skid_q;   // second instruction, captured while MEM stalls
   logic   accept;
   logic   emit;

   assign in_e = '{ctrl: in_ctrl, pc: in_pc, alu: in_alu, store: in_store,
                   zero: in_zero, dst: in_dst};

   // in_ready also depends on Rst so that nothing is offered as accepted
   // during reset.
   assign in_ready  = (state != FULL) & ~Rst;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= EMPTY;
         // NOTE: the data registers are reset because the reset values of
         // out_* are visible; this is not just a precaution.
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         // Data fields keep their last values; only the state goes empty.
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= in_e;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_q <= in_e;
               end else if (accept) begin
                  skid_q <= in_e;
                  state  <= FULL;
               end else if (emit) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               // The skid entry is older than anything upstream, so it moves
               // forward first. This keeps the order strictly FIFO.
               if (emit) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_ctrl  = out_valid ? main_q.ctrl : '0;
   assign out_pc    = main_q.pc;
   assign out_alu   = main_q.alu;
   assign out_store = main_q.store;
   assign out_zero  = main_q.zero;
   assign out_dst   = main_q.dst;

`ifdef EXMEM_PERF_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_exmem_skid_stage
//   Self-checking bench for exmem_skid_stage. A table of directed vectors
//   carries hand-derived expectations. Every cycle, including the directed
//   ones, is also compared against a queue-based reference model. A random
//   phase follows, plus a stall_cnt sequence when EXMEM_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_exmem_skid_stage;

   logic        Clk;
   logic        Rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_ctrl;
   logic [31:0] in_pc;
   logic [31:0] in_alu;
   logic [31:0] in_store;
   logic        in_zero;
   logic [4:0]  in_dst;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_ctrl;
   logic [31:0] out_pc;
   logic [31:0] out_alu;
   logic [31:0] out_store;
   logic        out_zero;
   logic [4:0]  out_dst;
`ifdef EXMEM_PERF_EN
   logic [31:0] stall_cnt;
`endif

   exmem_skid_stage dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_pc     (in_pc),
      .in_alu    (in_alu),
      .in_store  (in_store),
      .in_zero   (in_zero),
      .in_dst    (in_dst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_pc    (out_pc),
      .out_alu   (out_alu),
      .out_store (out_store),
      .out_zero  (out_zero),
      .out_dst   (out_dst)
`ifdef EXMEM_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: an in-order queue of entries ----------
   typedef struct packed {
      logic [4:0]  ctrl;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] st;
      logic        z;
      logic [4:0]  d;
   } ent_t;

   ent_t        q[$];
   ent_t        held = '0;     // entry last shown on the data outputs
   logic [31:0] m_stall = '0;
   logic        ir_seen;

   // Drive one cycle. Inputs are applied, in_ready is sampled before the edge,
   // the model steps on the edge, and the outputs are compared at the negedge.
   task automatic apply(input logic r, input logic f, input logic v,
                        input logic [4:0] c, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic z, input logic [4:0] d, input logic ordy);
      int   pre;
      ent_t e;
      Rst = r; flush = f; in_valid = v; in_ctrl = c; in_pc = pc;
      in_alu = alu; in_store = st; in_zero = z; in_dst = d; out_ready = ordy;
      #1;
      ir_seen = in_ready;
      check("model in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) && !r});
      @(posedge Clk);
      pre = q.size();
      e = '{ctrl: c, pc: pc, alu: alu, st: st, z: z, d: d};
      if (r) begin
         q.delete();
         held = '0;
         m_stall = '0;
      end else begin
         if (pre > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (f) begin
            q.delete();
         end else begin
            if (pre > 0 && ordy) void'(q.pop_front());
            if (v && pre < 2) q.push_back(e);
         end
         if (q.size() > 0) held = q[0];
      end
      @(negedge Clk);
      check("model out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      check("model out_ctrl", {59'd0, out_ctrl}, {59'd0, (q.size() > 0) ? held.ctrl : 5'd0});
      check("model out_pc", {32'd0, out_pc}, {32'd0, held.pc});
      check("model out_alu", {32'd0, out_alu}, {32'd0, held.alu});
      check("model out_store", {32'd0, out_store}, {32'd0, held.st});
      check("model out_zero", {63'd0, out_zero}, {63'd0, held.z});
      check("model out_dst", {59'd0, out_dst}, {59'd0, held.d});
`ifdef EXMEM_PERF_EN
      check("model stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
`endif
   endtask

   // Directed vectors. The other fields are derived from alu.
   task automatic apply_s(input logic r, input logic f, input logic v,
                          input logic [4:0] c, input logic [31:0] alu, input logic ordy);
      apply(r, f, v, c, alu << 2, alu, ~alu, alu == 32'd0, alu[4:0], ordy);
   endtask

   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic [4:0]  ctrl;
      logic [31:0] alu;
      logic        ordy;
      logic        e_ir;    // in_ready before the edge
      logic        e_ov;    // outputs after the edge
      logic [4:0]  e_oc;
      logic [31:0] e_oa;
   } vec_t;

   vec_t tbl[$];

   initial begin
      Rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_pc = '0;
      in_alu = '0; in_store = '0; in_zero = 1'b0; in_dst = '0; out_ready = 1'b0;

      //            rst fl iv ctrl      alu    ordy ir ov oc        oa
      // reset held two cycles with in_valid high
      tbl.push_back('{1, 0, 1, 5'd3,    32'h99, 1, 0, 0, 5'd0,    32'h0});
      tbl.push_back('{1, 0, 1, 5'd3,    32'h99, 1, 0, 0, 5'd0,    32'h0});
      // streaming, one-cycle latency
      tbl.push_back('{0, 0, 1, 5'd3,    32'h10, 1, 1, 1, 5'd3,    32'h10});
      tbl.push_back('{0, 0, 1, 5'd3,    32'h20, 1, 1, 1, 5'd3,    32'h20});
      tbl.push_back('{0, 0, 1, 5'd3,    32'h30, 1, 1, 1, 5'd3,    32'h30});
      tbl.push_back('{0, 0, 1, 5'd3,    32'h40, 1, 1, 1, 5'd3,    32'h40});
      // bubble gating: ctrl drops, alu retained
      tbl.push_back('{0, 0, 0, 5'd3,    32'h0,  1, 1, 0, 5'd0,    32'h40});
      tbl.push_back('{0, 0, 0, 5'd3,    32'h0,  1, 1, 0, 5'd0,    32'h40});
      // skid: A, B held, C stalled, then drained in order
      tbl.push_back('{0, 0, 1, 5'd3,    32'hA,  0, 1, 1, 5'd3,    32'hA});
      tbl.push_back('{0, 0, 1, 5'd3,    32'hB,  0, 1, 1, 5'd3,    32'hA});
      tbl.push_back('{0, 0, 1, 5'd3,    32'hC,  0, 0, 1, 5'd3,    32'hA});
      tbl.push_back('{0, 0, 1, 5'd3,    32'hC,  1, 0, 1, 5'd3,    32'hB});
      tbl.push_back('{0, 0, 1, 5'd3,    32'hC,  1, 1, 1, 5'd3,    32'hC});
      tbl.push_back('{0, 0, 0, 5'd3,    32'h0,  1, 1, 0, 5'd0,    32'hC});
      // flush while FULL, then a normal accept
      tbl.push_back('{0, 0, 1, 5'd3,    32'h50, 0, 1, 1, 5'd3,    32'h50});
      tbl.push_back('{0, 0, 1, 5'd3,    32'h60, 0, 1, 1, 5'd3,    32'h50});
      tbl.push_back('{0, 1, 1, 5'b10001, 32'h70, 0, 0, 0, 5'd0,   32'h50});
      tbl.push_back('{0, 0, 1, 5'b10001, 32'h80, 1, 1, 1, 5'b10001, 32'h80});
      tbl.push_back('{0, 0, 0, 5'd0,    32'h0,  1, 1, 0, 5'd0,    32'h80});
      // flush while EMPTY discards the same-cycle accept
      tbl.push_back('{0, 1, 1, 5'd3,    32'h90, 1, 1, 0, 5'd0,    32'h80});
      tbl.push_back('{0, 0, 0, 5'd3,    32'h0,  1, 1, 0, 5'd0,    32'h80});
      // reset while FULL: both entries lost, outputs cleared
      tbl.push_back('{0, 0, 1, 5'd3,    32'h1,  0, 1, 1, 5'd3,    32'h1});
      tbl.push_back('{0, 0, 1, 5'd3,    32'h2,  0, 1, 1, 5'd3,    32'h1});
      tbl.push_back('{1, 0, 1, 5'd3,    32'h3,  0, 0, 0, 5'd0,    32'h0});
      tbl.push_back('{0, 0, 0, 5'd3,    32'h0,  1, 1, 0, 5'd0,    32'h0});

      @(negedge Clk);
      foreach (tbl[i]) begin
         apply_s(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ctrl, tbl[i].alu, tbl[i].ordy);
         check($sformatf("vec%0d in_ready", i), {63'd0, ir_seen}, {63'd0, tbl[i].e_ir});
         check($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
         check($sformatf("vec%0d out_ctrl", i), {59'd0, out_ctrl}, {59'd0, tbl[i].e_oc});
         check($sformatf("vec%0d out_alu", i), {32'd0, out_alu}, {32'd0, tbl[i].e_oa});
      end

`ifdef EXMEM_PERF_EN
      // Stall counter: seven stalled cycles with a valid output. A flush
      // taken with out_ready high adds nothing. Rst clears the count.
      apply_s(1, 0, 0, 5'd0, 32'h0, 0);
      apply_s(0, 0, 1, 5'd3, 32'h77, 0);
      for (int i = 0; i < 7; i++) apply_s(0, 0, 0, 5'd0, 32'h0, 0);
      check("stall_cnt after 7", {32'd0, stall_cnt}, 64'd7);
      apply_s(0, 1, 0, 5'd0, 32'h0, 1);
      check("stall_cnt after flush", {32'd0, stall_cnt}, 64'd7);
      apply_s(0, 0, 0, 5'd0, 32'h0, 1);
      check("stall_cnt idle", {32'd0, stall_cnt}, 64'd7);
      apply_s(1, 0, 0, 5'd0, 32'h0, 1);
      check("stall_cnt reset", {32'd0, stall_cnt}, 64'd0);
`endif

      // Random phase, checked only against the model.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
               ($urandom_range(0, 99) < 70), 5'($urandom), $urandom, $urandom,
               $urandom, 1'($urandom), 5'($urandom), ($urandom_range(0, 99) < 60));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exmem_skid_stage.md
Name: exmem_skid_stage

Overview:
- Parametrised successor of the EX/MEM pipeline register; sits between the execute stage and the memory stage.
- Registers the EX-stage results (control bits, PC, ALU result, store data, zero flag, destination register) with a valid/ready handshake and a 2-entry skid buffer.
- A memory-side stall never drops or duplicates an instruction, and a flush cleanly inserts bubbles.
- Control bits are forced to zero whenever the output is not valid, so a bubble never writes the register file or memory.

Parameters:
- DATA_W, 32, width of the PC, ALU result and store-data fields
- CTRL_W, 5, width of the control bundle (Branch, MemR, Mem2R, MemW, RegW packed LSB-first)
- REG_W, 5, destination register index width

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (branch taken / exception)
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  stage can accept; equals (state != FULL) & ~Rst
- in_ctrl  in  CTRL_W  control bundle
- in_pc  in  DATA_W  PC of instruction
- in_alu  in  DATA_W  ALU result
- in_store  in  DATA_W  store data (rt value after forwarding)
- in_zero  in  1  ALU zero flag
- in_dst  in  REG_W  write-back register index
- out_valid  out  1  MEM stage entry valid
- out_ready  in  1  MEM stage accepts
- out_ctrl  out  CTRL_W  control bundle, gated: zero when out_valid=0
- out_pc, out_alu, out_store  out  DATA_W  registered fields
- out_zero  out  1  registered zero flag
- out_dst  out  REG_W  registered destination

Behaviour:
- accept = in_valid & in_ready; emit = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. State is one of EMPTY, ONE, FULL; out_valid = (state != EMPTY).
- Transitions (no flush):
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept&emit -> ONE, main<=in. accept&~emit -> FULL, skid<=in. ~accept&emit -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. emit -> ONE, main<=skid. Otherwise hold (outputs stable while stalled).
- Latency: accept in cycle N -> out_valid in cycle N+1 when EMPTY, or when ONE with emit. Throughput 1 per cycle with out_ready held high. Strict FIFO order.
- in_valid while in_ready=0: ignored, nothing captured; upstream must hold.
- Flush: state -> EMPTY next cycle; out_valid=0, out_ctrl=0. A same-cycle accept is discarded. Data fields hold their previous values (don't-care). Flush overrides emit/accept; emit that cycle still counts as taken by MEM.
- Reset (priority over flush): state EMPTY; all out_* registers, including out_pc, out_alu, out_store, out_zero and out_dst, = 0; in_ready=0 while Rst=1, 1 the cycle after release.
- Reset asserted mid-stall with FULL: both entries lost, no output glitch other than going invalid.
- No arithmetic performed; all fields are pass-through at their declared widths.

Optional Feature:
- Macro EXMEM_PERF_EN.
- Defined: adds output stall_cnt (out, 32): increments each cycle out_valid & ~out_ready, saturates at 32'hFFFFFFFF, cleared only by Rst (not flush); register adds 1 cycle of visibility latency.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: Rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_alu=0, in_ready=0; after release in_ready=1.
- Streaming: 4 instructions with alu=0x10,0x20,0x30,0x40, out_ready=1 -> out_alu 0x10..0x40 on consecutive cycles, 1-cycle latency.
- Skid: out_ready=0 while 3 instructions (alu=0xA,0xB,0xC) offered -> 0xA and 0xB held, in_ready=0 after 2nd accept, 0xC stalled; out_ready=1 -> 0xA,0xB,0xC emitted in order, none lost or duplicated.
- Flush in FULL: flush=1 with in_valid=1 (ctrl=5'b10001) -> next cycle out_valid=0, out_ctrl=0; next accepted instruction appears normally.
- Bubble gating: idle cycles after emit -> out_ctrl=0 although out_alu retains last value.
- EXMEM_PERF_EN: out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7; flush leaves 7; Rst clears to 0.
